// File: rtl/intpol2_iq_out_reader.sv
// Drain side of the interpolator's I/Q output FIFO pair.
// Reads both output FIFOs in lockstep, absorbs their 1-cycle read latency in a
// 2-entry skid buffer, and presents each pair as {Q,I} on a valid/ready stream.
// Transfers are counted against a programmed length; done/busy/aborted are
// reported in status_reg format.
//
// Handshake: a pair moves on every cycle where m_valid_o & m_ready_i are both 1.
// m_valid_o never depends on m_ready_i. Once m_valid_o is raised, it and m_data_o
// stay stable until the pair is accepted; the only exception is abort, which
// drops the stream immediately.
module intpol2_iq_out_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic                    Empty_I_i,
  input  logic                    Empty_Q_i,
  input  logic [DATA_WIDTH-1:0]   data_from_fifo_I,
  input  logic [DATA_WIDTH-1:0]   data_from_fifo_Q,
  output logic                    Read_Enable_fifo,
  output logic [2*DATA_WIDTH-1:0] m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [CNT_WIDTH-1:0]    count_o,
  output logic [7:0]              status_reg,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2*DATA_WIDTH-1:0] skid [2];
  logic                    head;
  logic                    tail;
  logic [1:0]              occ;
  logic                    inflight;
  logic [CNT_WIDTH-1:0]    issued;
  logic [CNT_WIDTH-1:0]    count;
  logic [CNT_WIDTH-1:0]    len;
  logic                    aborted;

  logic                    run;
  logic                    abort_run;
  logic                    pop;
  logic                    capture;
  logic [2:0]              fill_after;
  logic                    room;
  logic                    under_len;
  logic                    last_accept;

  assign run       = (state == RUN);
  assign abort_run = run & abort;

  // Stream side: head of the skid buffer, suppressed the moment abort arrives.
  assign m_valid_o = (occ != 2'd0) & ~abort_run;
  assign m_data_o  = skid[head];
  assign pop       = m_valid_o & m_ready_i;

  // A read issued last cycle lands now; during abort it is simply dropped.
  assign capture   = inflight & run & ~abort;
  assign tail      = head ^ occ[0];

  // Slots committed after this cycle (buffered + in flight - leaving now).
  // Counting this cycle's pop lets a new read overlap the pop, which is what
  // sustains one pair per cycle with the consumer always ready.
  assign fill_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign room       = (fill_after < 3'd2);
  assign under_len  = (len == '0) | (issued < len);

  assign Read_Enable_fifo = run & ~abort & ~Empty_I_i & ~Empty_Q_i & room & under_len;

  assign last_accept = pop & (len != '0) & ((count + CNT_WIDTH'(1)) == len);

  assign count_o    = count;
  assign status_reg = {5'b00000, aborted, (state != IDLE), (state == DONE)};
  assign fsm_state  = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start from IDLE, finish on the len-th accept, abort via FLUSH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort)            state_nxt = FLUSH;
        else if (last_accept) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      FLUSH:   if (!inflight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer bookkeeping: length latch, issue/accept counters, skid pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      issued   <= '0;
      count    <= '0;
      len      <= '0;
      aborted  <= 1'b0;
      head     <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= Read_Enable_fifo;
      if ((state == IDLE) && start) begin
        len     <= len_i;
        count   <= '0;
        issued  <= '0;
        aborted <= 1'b0;
      end else begin
        if (Read_Enable_fifo) issued <= issued + CNT_WIDTH'(1);
        if (pop)              count  <= count + CNT_WIDTH'(1);
      end
      if (abort_run) begin
        occ     <= 2'd0;
        head    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        if (pop) head <= ~head;
        occ <= occ + {1'b0, capture} - {1'b0, pop};
      end
    end
  end

  // Skid storage: returning FIFO data is written at the tail as {Q,I}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid[0] <= '0;
      skid[1] <= '0;
    end else if (capture) begin
      skid[tail] <= {data_from_fifo_Q, data_from_fifo_I};
    end
  end

endmodule

// File: tb/tb_intpol2_iq_out_reader.sv
// Bench for intpol2_iq_out_reader: FIFO pair responder, per-cycle compare
// process against a transaction-level model, directed and random scenarios.
module tb_intpol2_iq_out_reader;

  localparam int DW = 16;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] len_i;
  logic          Empty_I_i;
  logic          Empty_Q_i;
  logic [DW-1:0] data_from_fifo_I;
  logic [DW-1:0] data_from_fifo_Q;
  logic          Read_Enable_fifo;
  logic [2*DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [CW-1:0] count_o;
  logic [7:0]    status_reg;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  intpol2_iq_out_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .len_i            (len_i),
    .Empty_I_i        (Empty_I_i),
    .Empty_Q_i        (Empty_Q_i),
    .data_from_fifo_I (data_from_fifo_I),
    .data_from_fifo_Q (data_from_fifo_Q),
    .Read_Enable_fifo (Read_Enable_fifo),
    .m_data_o         (m_data_o),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .count_o          (count_o),
    .status_reg       (status_reg),
    .fsm_state        (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   fifo_i[$];
  logic [DW-1:0]   fifo_q[$];
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] pend_q[$];
  bit              gap = 1'b0;
  bit              force_eq = 1'b0;
  bit              fifo_re_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO pair responder (1-cycle read latency) ----------------
  initial begin
    data_from_fifo_I = '0;
    data_from_fifo_Q = '0;
    Empty_I_i = 1'b1;
    Empty_Q_i = 1'b1;
    forever begin
      @(negedge clk);
      fifo_re_s = Read_Enable_fifo && !rst;
      @(posedge clk);
      #1;
      if (fifo_re_s && fifo_i.size() > 0 && fifo_q.size() > 0) begin
        data_from_fifo_I = fifo_i.pop_front();
        data_from_fifo_Q = fifo_q.pop_front();
      end
      #1;
      Empty_I_i = (fifo_i.size() == 0) || gap;
      Empty_Q_i = (fifo_q.size() == 0) || gap || force_eq;
    end
  end

  // ---------------- behavioural model + compare process ----------------
  bit          run_m = 1'b0;     // a transfer is in progress
  int          tail_m = 0;       // busy cycles left after transfer ends
  bit          done_m = 1'b0;
  bit          abt_m = 1'b0;
  logic [CW-1:0] len_m = '0;
  logic [CW-1:0] cnt_m = '0;
  logic [CW-1:0] iss_m = '0;
  int          outst_m = 0;      // pairs read but not yet accepted
  bit          exp_busy;
  bit          acc;
  bit          prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data = '0;
  logic [2*DW-1:0] first_data = '0;
  logic [2*DW-1:0] last_data = '0;
  int cyc = 0;
  int done_cnt = 0, re_cnt = 0, acc_cnt = 0;
  int first_valid_cyc = -1, last_acc_cyc = -1, start_cyc = -1, done_cyc = -1;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      chk("rst_outputs", {Read_Enable_fifo, m_data_o, m_valid_o, count_o, status_reg}, 64'd0);
      run_m = 0; tail_m = 0; done_m = 0; abt_m = 0;
      len_m = '0; cnt_m = '0; iss_m = '0; outst_m = 0; prev_stall = 0;
    end else begin
      exp_busy = run_m || (tail_m > 0);
      chk("busy", status_reg[1], exp_busy);
      chk("done", status_reg[0], done_m);
      chk("aborted", status_reg[2], abt_m);
      chk("status_hi", status_reg[7:3], 64'd0);
      chk("count", count_o, cnt_m);
      chk("state_vs_busy", fsm_state != 2'd0, exp_busy);
      if (status_reg[0]) begin done_cnt++; done_cyc = cyc; end
      if (run_m && abort) chk("valid_on_abort", m_valid_o, 0);
      if (!exp_busy) chk("valid_idle", m_valid_o, 0);
      if (prev_stall && !(run_m && abort)) begin
        chk("stall_valid", m_valid_o, 1);
        chk("stall_data", m_data_o, prev_data);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (Read_Enable_fifo) begin
        re_cnt++;
        chk("re_empty", {Empty_I_i, Empty_Q_i}, 64'd0);
        chk("re_allowed", run_m && !abort && (len_m == 0 || iss_m < len_m), 1);
        iss_m++;
      end
      acc = m_valid_o && m_ready_i;
      if (acc) begin
        last_acc_cyc = cyc;
        acc_cnt++;
        if (acc_cnt == 1) first_data = m_data_o;
        last_data = m_data_o;
        if (exp_q.size() == 0) chk("extra_pair", m_data_o, 64'hx);
        else chk("pair", m_data_o, exp_q.pop_front());
      end
      outst_m = outst_m + int'(Read_Enable_fifo) - int'(acc);
      chk("outstanding_le2", outst_m <= 2, 1);
      // advance the model to the next cycle
      done_m = 0;
      if (tail_m > 0) tail_m--;
      if (!exp_busy && start) begin
        run_m = 1; len_m = len_i; cnt_m = '0; iss_m = '0; abt_m = 0; outst_m = 0;
        start_cyc = cyc;
      end else if (run_m) begin
        if (abort) begin
          run_m = 0; abt_m = 1; tail_m = 1; outst_m = 0;
        end else if (acc) begin
          cnt_m++;
          if (len_m != 0 && cnt_m == len_m) begin
            run_m = 0; done_m = 1; tail_m = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    fifo_i.delete();
    fifo_q.delete();
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic begin_test();
    done_cnt = 0; re_cnt = 0; acc_cnt = 0;
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_pair(input logic [DW-1:0] i, input logic [DW-1:0] q);
    fifo_i.push_back(i);
    fifo_q.push_back(q);
    exp_q.push_back({q, i});
  endtask

  task automatic add_pending(input logic [DW-1:0] i, input logic [DW-1:0] q);
    pend_q.push_back({q, i});
    exp_q.push_back({q, i});
  endtask

  task automatic pulse_start(input logic [CW-1:0] l);
    tick();
    len_i = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready toggles; 2: random ready, FIFO gaps, trickle refill.
  // stop_at < 0 waits for idle, otherwise for the model count to reach stop_at.
  task automatic run_until(input int mode, input int budget, input int stop_at);
    bit hit;
    logic [2*DW-1:0] pp;
    hit = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (stop_at < 0 ? (!run_m && tail_m == 0) : (int'(cnt_m) == stop_at)) begin
        hit = 1;
        break;
      end
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      gap = (mode == 2) && ($urandom_range(0, 3) == 0);
      if (pend_q.size() > 0 && (mode != 2 || $urandom_range(0, 1) == 1)) begin
        pp = pend_q.pop_front();
        fifo_i.push_back(pp[DW-1:0]);
        fifo_q.push_back(pp[2*DW-1:DW]);
      end
    end
    chk("run_timeout", hit, 1);
    gap = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len_i = '0; m_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1: len 4, preloaded, ready high -> back-to-back stream
    begin_test();
    for (int k = 1; k <= 4; k++) push_pair(16'(k), 16'(-k));
    m_ready_i = 1'b1;
    tick(); tick();
    pulse_start(16'd4);
    run_until(0, 100, -1);
    chk("t1_re_cycles", re_cnt, 4);
    chk("t1_first_valid", first_valid_cyc - start_cyc, 3);
    chk("t1_back_to_back", last_acc_cyc - first_valid_cyc, 3);
    chk("t1_done_cycle", done_cyc - start_cyc, 7);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_count", count_o, 4);
    chk("t1_first_pair", first_data, 32'hFFFF_0001);
    chk("t1_last_pair", last_data, 32'hFFFC_0004);
    chk("t1_drained", exp_q.size(), 0);

    // T2: len 8, ready toggling
    clear_all(); begin_test();
    for (int k = 0; k < 8; k++) push_pair(16'($urandom), 16'($urandom));
    tick(); tick();
    pulse_start(16'd8);
    run_until(1, 200, -1);
    chk("t2_accepted", acc_cnt, 8);
    chk("t2_done_once", done_cnt, 1);
    chk("t2_count", count_o, 8);
    chk("t2_drained", exp_q.size(), 0);

    // T3: Q FIFO empty while I has data -> nothing read
    clear_all(); begin_test();
    force_eq = 1'b1; m_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) push_pair(16'($urandom), 16'($urandom));
    tick(); tick();
    pulse_start(16'd3);
    for (int k = 0; k < 20; k++) tick();
    chk("t3_no_read", re_cnt, 0);
    chk("t3_no_valid", first_valid_cyc, -1);
    chk("t3_still_busy", status_reg[1], 1);
    abort = 1'b1; tick(); abort = 1'b0;
    run_until(0, 20, -1);
    force_eq = 1'b0;

    // T4: unbounded, abort after 10 accepted
    clear_all(); begin_test();
    for (int k = 0; k < 20; k++) push_pair(16'($urandom), 16'($urandom));
    tick(); tick();
    pulse_start(16'd0);
    run_until(0, 100, 10);
    abort = 1'b1;
    @(negedge clk);
    chk("t4_re_drop", Read_Enable_fifo, 0);
    tick(); abort = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_status", status_reg, 8'h04);
    chk("t4_count", count_o, 10);
    chk("t4_no_done", done_cnt, 0);

    // T5: reset mid-transfer, then a clean len-2 transfer
    clear_all(); begin_test();
    for (int k = 0; k < 6; k++) push_pair(16'($urandom), 16'($urandom));
    tick(); tick();
    pulse_start(16'd6);
    run_until(0, 100, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_re", Read_Enable_fifo, 0);
    chk("t5_rst_status", status_reg, 8'h00);
    chk("t5_rst_count", count_o, 0);
    tick(); rst = 1'b0;
    clear_all(); begin_test();
    push_pair(16'h1234, 16'h8765);
    push_pair(16'h0F0F, 16'hF0F0);
    tick(); tick();
    pulse_start(16'd2);
    run_until(0, 100, -1);
    chk("t5_count", count_o, 2);
    chk("t5_done_once", done_cnt, 1);
    chk("t5_last_pair", last_data, 32'hF0F0_0F0F);

    // T6: second start while busy is ignored
    clear_all(); begin_test();
    for (int k = 0; k < 5; k++) push_pair(16'($urandom), 16'($urandom));
    for (int k = 0; k < 4; k++) push_pair(16'($urandom), 16'($urandom));
    tick(); tick();
    pulse_start(16'd5);
    run_until(1, 100, 2);
    pulse_start(16'd9);
    run_until(1, 200, -1);
    chk("t6_count", count_o, 5);
    chk("t6_done_once", done_cnt, 1);
    chk("t6_leftover", exp_q.size(), 4);

    // T7: random lengths, random ready, FIFO gaps and trickle refill
    for (int r = 0; r < 8; r++) begin
      int l;
      clear_all(); begin_test();
      l = $urandom_range(1, 12);
      for (int k = 0; k < l; k++) add_pending(16'($urandom), 16'($urandom));
      pulse_start(16'(l));
      run_until(2, 800, -1);
      chk("t7_count", count_o, 64'(l));
      chk("t7_done_once", done_cnt, 1);
      chk("t7_drained", exp_q.size(), 0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
